// File: rtl/stdp_grad_unit_if.sv
// Handshake-free sample/gradient bundle between the spike source, stdp_grad_unit and the optimizer.
interface stdp_grad_unit_if #(
    parameter int unsigned BATCH_LOG2 = 2
);
    localparam int unsigned CW = (BATCH_LOG2 == 0) ? 1 : BATCH_LOG2;

    logic              en;
    logic              pre_spike;
    logic              post_spike;
    logic signed [7:0] error_in;
    logic signed [7:0] grad_out;
    logic              update_spike;
    logic [7:0]        pre_trace;
    logic [CW-1:0]     batch_cnt;

    modport master (
        output en, pre_spike, post_spike, error_in,
        input  grad_out, update_spike, pre_trace, batch_cnt
    );

    modport slave (
        input  en, pre_spike, post_spike, error_in,
        output grad_out, update_spike, pre_trace, batch_cnt
    );
endinterface

// File: rtl/stdp_grad_unit.sv
// Decaying presynaptic trace, error x trace products on post spikes, batched
// into an averaged saturated 8-bit gradient with a one-cycle update pulse.
module stdp_grad_unit #(
    parameter int unsigned DECAY_SHIFT = 2,
    parameter int unsigned TRACE_INC   = 64,
    parameter int unsigned PROD_SHIFT  = 6,
    parameter int unsigned BATCH_LOG2  = 2
) (
    input  logic            clk,
    input  logic            rst,
    stdp_grad_unit_if.slave bus
);
    localparam int unsigned CW = (BATCH_LOG2 == 0) ? 1 : BATCH_LOG2;

    logic [7:0]         trace_q;
    logic signed [15:0] prod_q;
    logic               p1_valid_q;
    logic signed [15:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic signed [7:0]  grad_q;
    logic               upd_q;

    logic [7:0]         dec_c;
    logic [8:0]         inc_c;
    logic [7:0]         trace_nxt_c;
    logic signed [15:0] prod_c;
    logic signed [15:0] term_c;
    logic signed [16:0] sum_wide_c;
    logic signed [15:0] sum_c;
    logic signed [15:0] avg_c;
    logic signed [7:0]  grad_c;
    logic               last_c;

    // Trace decay with a floor to zero, then a saturating 9-bit increment
    always_comb begin
        dec_c = 8'd0;
        if ({1'b0, trace_q} >= 9'(2 ** DECAY_SHIFT))
            dec_c = trace_q - (trace_q >> DECAY_SHIFT);
        inc_c       = {1'b0, dec_c} + 9'(TRACE_INC);
        trace_nxt_c = dec_c;
        if (bus.pre_spike)
            trace_nxt_c = inc_c[8] ? 8'hFF : inc_c[7:0];
    end

    assign prod_c = $signed({{8{bus.error_in[7]}}, bus.error_in}) * $signed({8'd0, trace_q});

    // Accumulate with 16-bit saturation, average and clamp to 8 bits
    always_comb begin
        term_c     = prod_q >>> PROD_SHIFT;
        sum_wide_c = {acc_q[15], acc_q} + {term_c[15], term_c};
        sum_c      = sum_wide_c[15:0];
        if (sum_wide_c[16] != sum_wide_c[15])
            sum_c = sum_wide_c[16] ? 16'sh8000 : 16'sh7FFF;
        avg_c  = sum_c >>> BATCH_LOG2;
        grad_c = avg_c[7:0];
        if (avg_c > 16'sd127)
            grad_c = 8'sh7F;
        else if (avg_c < -16'sd128)
            grad_c = 8'sh80;
        last_c = (cnt_q == CW'(2 ** BATCH_LOG2 - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_q    <= 8'd0;
            prod_q     <= 16'sd0;
            p1_valid_q <= 1'b0;
        end else begin
            if (bus.en)
                trace_q <= trace_nxt_c;
            p1_valid_q <= bus.en && bus.post_spike;
            if (bus.en && bus.post_spike)
                prod_q <= prod_c;
        end
    end

    // Stage 2 drains regardless of en so a captured sample is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= 16'sd0;
            cnt_q  <= '0;
            grad_q <= 8'sd0;
            upd_q  <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (p1_valid_q) begin
                if (last_c) begin
                    grad_q <= grad_c;
                    upd_q  <= 1'b1;
                    acc_q  <= 16'sd0;
                    cnt_q  <= '0;
                end else begin
                    acc_q <= sum_c;
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign bus.pre_trace    = trace_q;
    assign bus.grad_out     = grad_q;
    assign bus.update_spike = upd_q;
    assign bus.batch_cnt    = cnt_q;
endmodule

// File: tb/tb_stdp_grad_unit.sv
// Directed bench for stdp_grad_unit: expected gradients queued by the stimulus, checked by a monitor.
module tb_stdp_grad_unit;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        int grad;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    stdp_grad_unit_if #(.BATCH_LOG2(2)) bus ();

    stdp_grad_unit #(
        .DECAY_SHIFT(2), .TRACE_INC(64), .PROD_SHIFT(6), .BATCH_LOG2(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Drive one cycle at the falling edge; return at the next falling edge
    task automatic drive(input logic en, input logic pre, input logic post, input int err);
        bus.en         = en;
        bus.pre_spike  = pre;
        bus.post_spike = post;
        bus.error_in   = 8'(err);
        @(negedge clk);
    endtask

    // Last post of a batch: update pulse expected two edges after sampling
    task automatic drive_last(input logic pre, input int err, input int grad);
        exp_t e;
        e.grad = grad;
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
        drive(1'b1, pre, 1'b1, err);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.update_spike === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("grad_out", int'(bus.grad_out), e.grad);
                end
            end
        end
    endtask

    initial begin
        int decay_seq[15] = '{64, 48, 36, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 0, 0};
        int sat_seq[5]    = '{64, 112, 148, 175, 196};

        rst            = 1'b1;
        bus.en         = 1'b0;
        bus.pre_spike  = 1'b0;
        bus.post_spike = 1'b0;
        bus.error_in   = 8'sd0;
        fork
            monitor();
        join_none
        @(negedge clk);
        @(negedge clk);
        check("rst_trace", int'(bus.pre_trace), 0);
        check("rst_grad", int'(bus.grad_out), 0);
        check("rst_upd", int'(bus.update_spike), 0);
        check("rst_cnt", int'(bus.batch_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single pre spike, then free decay to zero
        drive(1'b1, 1'b1, 1'b0, 0);
        check("decay_0", int'(bus.pre_trace), decay_seq[0]);
        for (int i = 1; i < 15; i++) begin
            drive(1'b1, 1'b0, 1'b0, 0);
            check($sformatf("decay_%0d", i), int'(bus.pre_trace), decay_seq[i]);
        end

        // Held pre spike climbs to and stays at 255
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 0);
            check($sformatf("sat_%0d", i), int'(bus.pre_trace), sat_seq[i]);
        end
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 0);
        check("sat_255", int'(bus.pre_trace), 255);
        drive(1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b0, 0);
        check("sat_hold", int'(bus.pre_trace), 255);

        // Positive batch: terms 506, sum 2024, clamps to 127
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 127);
        drive_last(1'b1, 127, 127);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 0);
        check("pos_cnt", int'(bus.batch_cnt), 0);
        check("pos_hold", int'(bus.grad_out), 127);

        // Negative batch: terms -32 -> -32
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, -8);
        drive_last(1'b1, -8, -32);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 0);
        check("neg_hold", int'(bus.grad_out), -32);

        // Mid-range batch: terms 63 -> 63
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 16);
        drive_last(1'b1, 16, 63);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 0);
        check("mid_hold", int'(bus.grad_out), 63);

        // en gating: 63+63 accepted, 5 ignored posts, then -32-32 -> 62>>>2 = 15
        drive(1'b1, 1'b1, 1'b1, 16);
        drive(1'b1, 1'b1, 1'b1, 16);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 100);
            check($sformatf("gate_trace_%0d", i), int'(bus.pre_trace), 255);
            check($sformatf("gate_cnt_%0d", i), int'(bus.batch_cnt), 2);
        end
        drive(1'b1, 1'b1, 1'b1, -8);
        drive_last(1'b1, -8, 15);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 0);
        check("gate_grad", int'(bus.grad_out), 15);

        // Mid-batch async reset discards partial batch
        drive(1'b1, 1'b1, 1'b1, 10);
        drive(1'b1, 1'b1, 1'b1, 10);
        drive(1'b1, 1'b1, 1'b0, 0);
        check("pre_rst_cnt", int'(bus.batch_cnt), 2);
        #2 rst = 1'b1;
        #1;
        check("arst_trace", int'(bus.pre_trace), 0);
        check("arst_grad", int'(bus.grad_out), 0);
        check("arst_upd", int'(bus.update_spike), 0);
        check("arst_cnt", int'(bus.batch_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Fresh batch after reset: traces 64,48,36,27 x 64 -> terms sum 175 -> 43
        drive(1'b1, 1'b1, 1'b0, 0);
        check("post_rst_trace", int'(bus.pre_trace), 64);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 64);
        drive_last(1'b0, 64, 43);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 0);
        check("post_rst_grad", int'(bus.grad_out), 43);

        check("pending_pulses", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stdp_grad_unit.md
# stdp_grad_unit

Trace-based gradient generator sitting directly upstream of the synaptic weight optimizer. It keeps an exponentially decaying presynaptic eligibility trace and, on each postsynaptic spike, forms an error × trace product. It accumulates a batch of such products and emits an averaged, saturated 8-bit gradient. The gradient comes with a one-cycle update pulse that drives the optimizer's `grad_in` and `spike` inputs.

## Interface
- `DECAY_SHIFT`, 2: trace decay per cycle is `trace >> DECAY_SHIFT`.
- `TRACE_INC`, 64: amount added to the trace on a pre spike (unsigned 8-bit).
- `PROD_SHIFT`, 6: arithmetic right shift applied to each error × trace product.
- `BATCH_LOG2`, 2: batch size is 2^BATCH_LOG2 post-spike samples (range 0..7).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: learning enable; gates the trace and stage-1 capture.
- `pre_spike` in 1: presynaptic spike, sampled each cycle.
- `post_spike` in 1: postsynaptic spike, sampled each cycle.
- `error_in` in 8, signed: error term, sampled with `post_spike`.
- `grad_out` out 8, signed, registered: last emitted gradient; feeds optimizer `grad_in`.
- `update_spike` out 1, registered: one-cycle pulse when `grad_out` is new; feeds optimizer `spike`.
- `pre_trace` out 8, unsigned, registered: current trace value.
- `batch_cnt` out BATCH_LOG2 bits (minimum 1 bit): samples accumulated in the current batch.

## Operation
**Reset (async, rst=1)**
- `pre_trace`, `grad_out`, `update_spike`, `batch_cnt`, the internal accumulator, the product register and `p1_valid` are all cleared to 0 immediately.
- Reset mid-batch discards the partial batch. No update pulse is produced.

**Trace (en=1)**
- `dec = (t < 2^DECAY_SHIFT) ? 0 : t - (t >> DECAY_SHIFT)`.
- Next trace = `pre_spike ? min(dec + TRACE_INC, 255) : dec`. The add is done at 9 bits and then saturated.
- When en=0 the trace holds.

**Stage 1 (capture)**
- When `en && post_spike`: `prod <= error_in * pre_trace`. The product is 16-bit signed, with `pre_trace` zero-extended. Set `p1_valid <= 1`; otherwise `p1_valid <= 0`.
- The product uses the trace register value before this edge's trace update.
- Worst-case product range is -32640..32385, so it never overflows 16 bits.

**Stage 2 (accumulate/emit)**
- Stage 2 runs whenever `p1_valid` = 1, independent of `en`, so an in-flight sample always drains.
- `term = prod >>> PROD_SHIFT`, arithmetic shift with floor rounding.
- `sum = sat16(acc + term)`.
- If `batch_cnt == 2^BATCH_LOG2 - 1`:
  - `grad_out <= sat8(sum >>> BATCH_LOG2)`, saturating to -128..127.
  - `update_spike <= 1`.
  - `acc <= 0`, `batch_cnt <= 0`.
- Otherwise: `acc <= sum`, `batch_cnt <= batch_cnt + 1`, `update_spike <= 0`.
- When `p1_valid` = 0: `update_spike <= 0`, and `acc`, `batch_cnt` and `grad_out` hold.
- BATCH_LOG2=0 emits on every sample, with `batch_cnt` stuck at 0.

**Boundaries**
- `post_spike` may be asserted every cycle; full throughput is one sample per cycle, with no backpressure.
- `pre_spike` and `post_spike` in the same cycle: the product uses the old trace, and the trace still increments.
- en=0 while `post_spike` is high: the sample is ignored, and `batch_cnt` and `acc` hold.

## Timing
- Post spike sampled at edge N, then product registered at edge N.
- Accumulate or emit at edge N+1, so `update_spike` and the new `grad_out` are visible from edge N+1 until edge N+2.
- Latency from the `post_spike` input to the `update_spike` output is 2 edges.
- `grad_out` is stable whenever `update_spike` is high, so the optimizer samples both on the next edge.
- The trace updates every edge while en=1. `pre_trace` reflects the value after the most recent edge.

## Test plan
- **Reset:** assert rst mid-stream with `batch_cnt`=2 and trace=100 → all outputs read 0 immediately. After release, 4 posts are needed for the next emission.
- **Trace decay:** a single `pre_spike` from 0 gives the trace sequence 64, 48, 36, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 0. It then stays at 0.
- **Trace saturation:** hold `pre_spike` high → trace 64, 112, 148, 175, 196, … rises to 255 and holds at 255.
- **Positive batch with grad saturation:** trace at 255 (`pre_spike` held), error=127, 4 consecutive posts. Each term is 506 and the sum is 2024, so `grad_out`=127. `update_spike` pulses exactly once, 2 edges after the 4th post.
- **Negative and mid-range batches:** trace 255, error=-8, 4 posts → `grad_out`=-32. With error=16 → `grad_out`=63. Each batch gives one pulse, and `grad_out` holds between pulses.
- **en gating:** 2 posts, then en=0 for 5 cycles with `post_spike` high, then en=1 with 2 more posts. Expect no pulse during the en=0 window, trace frozen, `batch_cnt`=2 held, and a single emission after the 4th accepted post.
